// File: rtl/duck_pkg.sv
`default_nettype none
//============================================================================
// Package : duck_pkg
// Desc    : Shared types and constants for the duck sprite controller.
// Rev     : 1.0
//============================================================================
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLY    = 3'd1,
    ST_HIT    = 3'd2,
    ST_FALL   = 3'd3,
    ST_ESCAPE = 3'd4
  } duck_state_t;

  localparam int SPR_W    = 68;
  localparam int SPR_H    = 64;
  localparam int SCREEN_W = 640;

  localparam logic [2:0] FLY0  = 3'd0;
  localparam logic [2:0] FLY1  = 3'd1;
  localparam logic [2:0] FLY2  = 3'd2;
  localparam logic [2:0] HIT   = 3'd3;
  localparam logic [2:0] FALL0 = 3'd4;
  localparam logic [2:0] FALL1 = 3'd5;

  // Flying cycle wraps 0->1->2->0
  function automatic logic [2:0] next_fly_frame(input logic [2:0] cur);
    return (cur == FLY2) ? FLY0 : cur + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/duck_addr_gen.sv
`default_nettype none
//============================================================================
// Module : duck_addr_gen
// Desc   : Bounding box test, horizontal mirror and registered ROM address.
// Rev    : 1.0
//============================================================================
module duck_addr_gen
  import duck_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        active,
  input  logic        blank,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        dir,
  output logic [12:0] rom_address,
  output logic        duck_on
);

  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_in_box;
  logic [9:0]  w_col;
  logic [9:0]  w_col_m;
  logic [9:0]  w_row;
  logic [12:0] w_addr;
  logic [12:0] r_rom_address;
  logic        r_duck_on;

  // 11-bit ends so a sprite near the right/bottom edge never wraps
  assign w_x_end  = {1'b0, x} + 11'(SPR_W);
  assign w_y_end  = {1'b0, y} + 11'(SPR_H);
  assign w_in_x   = ({1'b0, draw_x} >= {1'b0, x}) && ({1'b0, draw_x} < w_x_end);
  assign w_in_y   = ({1'b0, draw_y} >= {1'b0, y}) && ({1'b0, draw_y} < w_y_end);
  assign w_in_box = blank && active && w_in_x && w_in_y;

  assign w_col   = draw_x - x;
  assign w_row   = draw_y - y;
  assign w_col_m = dir ? (10'(SPR_W - 1) - w_col) : w_col;
  assign w_addr  = 13'(w_row) * 13'(SPR_W) + 13'(w_col_m);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_address <= '0;
      r_duck_on     <= 1'b0;
    end else begin
      r_rom_address <= w_in_box ? w_addr : 13'd0;
      r_duck_on     <= w_in_box;
    end
  end

  assign rom_address = r_rom_address;
  assign duck_on     = r_duck_on;

endmodule
`default_nettype wire

// File: rtl/duck_sprite_ctrl.sv
`default_nettype none
//============================================================================
// Module : duck_sprite_ctrl
// Desc   : Duck life-cycle FSM, per-frame motion, animation and pixel address.
// Rev    : 1.0
//============================================================================
module duck_sprite_ctrl
  import duck_pkg::*;
#(
  parameter int FRAME_DIV = 6,
  parameter int HIT_HOLD  = 30,
  parameter int FLY_DX    = 2,
  parameter int FLY_DY    = 1,
  parameter int FALL_DY   = 4,
  parameter int TOP_Y     = 0,
  parameter int GROUND_Y  = 400
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        start,
  input  logic [9:0]  start_x,
  input  logic        start_dir,
  input  logic        shot,
  output logic [12:0] rom_address,
  output logic [2:0]  frame_sel,
  output logic        duck_on,
  output logic [9:0]  duck_x,
  output logic [9:0]  duck_y,
  output logic        busy,
  output logic        hit_pulse,
  output logic        escape_pulse,
  output logic        land_pulse
);

  localparam logic [7:0]  ANIM_LAST = 8'(FRAME_DIV - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(HIT_HOLD - 1);
  localparam logic [11:0] X_MAX     = 12'(SCREEN_W - SPR_W);
  localparam logic [10:0] ESC_LIMIT = 11'(TOP_Y + FLY_DY);
  localparam logic [9:0]  GROUND_V  = 10'(GROUND_Y);

  duck_state_t r_state, w_state;
  logic [9:0]  r_x, w_x;
  logic [9:0]  r_y, w_y;
  logic        r_dir, w_dir;
  logic [2:0]  r_frame_sel, w_frame_sel;
  logic [7:0]  r_anim_cnt, w_anim_cnt;
  logic [7:0]  r_hold_cnt, w_hold_cnt;
  logic        r_hit_pulse, w_hit_pulse;
  logic        r_escape_pulse, w_escape_pulse;
  logic        r_land_pulse, w_land_pulse;

  logic [11:0] w_nx;
  logic [10:0] w_fall_sum;
  logic        w_active;

  // Candidate x in two's complement so a left step past 0 shows as negative
  assign w_nx       = r_dir ? ({2'b00, r_x} - 12'(FLY_DX)) : ({2'b00, r_x} + 12'(FLY_DX));
  assign w_fall_sum = {1'b0, r_y} + 11'(FALL_DY);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_x            <= '0;
      r_y            <= '0;
      r_dir          <= 1'b0;
      r_frame_sel    <= '0;
      r_anim_cnt     <= '0;
      r_hold_cnt     <= '0;
      r_hit_pulse    <= 1'b0;
      r_escape_pulse <= 1'b0;
      r_land_pulse   <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_x            <= w_x;
      r_y            <= w_y;
      r_dir          <= w_dir;
      r_frame_sel    <= w_frame_sel;
      r_anim_cnt     <= w_anim_cnt;
      r_hold_cnt     <= w_hold_cnt;
      r_hit_pulse    <= w_hit_pulse;
      r_escape_pulse <= w_escape_pulse;
      r_land_pulse   <= w_land_pulse;
    end
  end

  always_comb begin
    w_state        = r_state;
    w_x            = r_x;
    w_y            = r_y;
    w_dir          = r_dir;
    w_frame_sel    = r_frame_sel;
    w_anim_cnt     = r_anim_cnt;
    w_hold_cnt     = r_hold_cnt;
    w_hit_pulse    = 1'b0;
    w_escape_pulse = 1'b0;
    w_land_pulse   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state     = ST_FLY;
          w_x         = start_x;
          w_y         = GROUND_V;
          w_dir       = start_dir;
          w_frame_sel = FLY0;
          w_anim_cnt  = '0;
        end
      end

      ST_FLY: begin
        // A shot outranks an escape landing on the same cycle
        if (shot) begin
          w_state     = ST_HIT;
          w_frame_sel = HIT;
          w_hold_cnt  = '0;
          w_hit_pulse = 1'b1;
        end else if (frame_start) begin
          if ({1'b0, r_y} <= ESC_LIMIT) begin
            w_state        = ST_ESCAPE;
            w_escape_pulse = 1'b1;
          end else begin
            w_y = r_y - 10'(FLY_DY);
            if (w_nx[11] || (w_nx == 12'd0)) begin
              w_x   = '0;
              w_dir = 1'b0;
            end else if (w_nx >= X_MAX) begin
              w_x   = X_MAX[9:0];
              w_dir = 1'b1;
            end else begin
              w_x = w_nx[9:0];
            end
            if (r_anim_cnt == ANIM_LAST) begin
              w_anim_cnt  = '0;
              w_frame_sel = next_fly_frame(r_frame_sel);
            end else begin
              w_anim_cnt = r_anim_cnt + 8'd1;
            end
          end
        end
      end

      ST_HIT: begin
        if (frame_start) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state     = ST_FALL;
            w_frame_sel = FALL0;
            w_anim_cnt  = '0;
          end else begin
            w_hold_cnt = r_hold_cnt + 8'd1;
          end
        end
      end

      ST_FALL: begin
        if (frame_start) begin
          if (w_fall_sum >= 11'(GROUND_Y)) begin
            w_y          = GROUND_V;
            w_state      = ST_IDLE;
            w_land_pulse = 1'b1;
          end else begin
            w_y = w_fall_sum[9:0];
            if (r_anim_cnt == ANIM_LAST) begin
              w_anim_cnt  = '0;
              w_frame_sel = (r_frame_sel == FALL0) ? FALL1 : FALL0;
            end else begin
              w_anim_cnt = r_anim_cnt + 8'd1;
            end
          end
        end
      end

      ST_ESCAPE: w_state = ST_IDLE;

      default: w_state = ST_IDLE;
    endcase
  end

  assign w_active = (r_state == ST_FLY) || (r_state == ST_HIT) || (r_state == ST_FALL);

  duck_addr_gen u_addr_gen (
    .clk         (vga_clk),
    .reset_n     (reset_n),
    .active      (w_active),
    .blank       (blank),
    .draw_x      (DrawX),
    .draw_y      (DrawY),
    .x           (r_x),
    .y           (r_y),
    .dir         (r_dir),
    .rom_address (rom_address),
    .duck_on     (duck_on)
  );

  assign frame_sel    = r_frame_sel;
  assign duck_x       = r_x;
  assign duck_y       = r_y;
  assign busy         = (r_state != ST_IDLE);
  assign hit_pulse    = r_hit_pulse;
  assign escape_pulse = r_escape_pulse;
  assign land_pulse   = r_land_pulse;

endmodule
`default_nettype wire
